// File: rtl/control_preparacion.sv
// Brew sequencer: heater, then coffee/milk/chocolate valves timed per latched coffee type, then a listo pulse.
// Outputs are registered from the next state, so they line up with the state register. There is no backpressure; one order at a time.
module control_preparacion #(
  parameter int T_CALENTAR  = 4,
  parameter int T_CAFE      = 3,
  parameter int T_LECHE     = 2,
  parameter int T_CHOCOLATE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciarProceso,
  input  logic [1:0] tipoCafe,
  input  logic       cancelar,
  output logic       calentador,
  output logic       valvulaCafe,
  output logic       valvulaLeche,
  output logic       valvulaChocolate,
  output logic       ocupado,
  output logic       listo,
  output logic       abortado,
  output logic [2:0] etapa
);

  localparam int TMAX_A = (T_CALENTAR > T_CAFE) ? T_CALENTAR : T_CAFE;
  localparam int TMAX_B = (T_LECHE > T_CHOCOLATE) ? T_LECHE : T_CHOCOLATE;
  localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  // The counter only ever holds T_x-1, so $clog2(TMAX) bits are enough.
  localparam int CW     = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CALENTAR  = 3'd1,
    CAFE      = 3'd2,
    LECHE     = 3'd3,
    CHOCOLATE = 3'd4,
    LISTO     = 3'd5,
    REARME    = 3'd6,
    ABORTO    = 3'd7
  } estado_t;

  estado_t         estado, estado_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [1:0]      tipo, tipo_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado           <= IDLE;
      cnt              <= '0;
      tipo             <= 2'd0;
      calentador       <= 1'b0;
      valvulaCafe      <= 1'b0;
      valvulaLeche     <= 1'b0;
      valvulaChocolate <= 1'b0;
      ocupado          <= 1'b0;
      listo            <= 1'b0;
      abortado         <= 1'b0;
      etapa            <= 3'd0;
    end else begin
      estado           <= estado_n;
      cnt              <= cnt_n;
      tipo             <= tipo_n;
      calentador       <= (estado_n == CALENTAR);
      valvulaCafe      <= (estado_n == CAFE);
      valvulaLeche     <= (estado_n == LECHE);
      valvulaChocolate <= (estado_n == CHOCOLATE);
      ocupado          <= (estado_n != IDLE);
      listo            <= (estado_n == LISTO);
      abortado         <= (estado_n == ABORTO);
      etapa            <= estado_n;
    end
  end

  always_comb begin
    estado_n = estado;
    tipo_n   = tipo;
    cnt_n    = (cnt != '0) ? cnt - CW'(1) : '0;
    case (estado)
      IDLE: begin
        cnt_n = '0;
        if (iniciarProceso) begin
          estado_n = CALENTAR;
          tipo_n   = tipoCafe;
          cnt_n    = CW'(T_CALENTAR - 1);
        end
      end
      CALENTAR: begin
        // Abort wins over the stage timeout: nothing has been dispensed yet.
        if (cancelar) begin
          estado_n = ABORTO;
          cnt_n    = '0;
        end else if (cnt == '0) begin
          estado_n = CAFE;
          cnt_n    = CW'(T_CAFE - 1);
        end
      end
      CAFE: begin
        if (cnt == '0) begin
          if (tipo == 2'd0) begin
            estado_n = LISTO;
            cnt_n    = '0;
          end else begin
            estado_n = LECHE;
            cnt_n    = CW'(T_LECHE - 1);
          end
        end
      end
      LECHE: begin
        if (cnt == '0) begin
          if (tipo == 2'd3) begin
            estado_n = CHOCOLATE;
            cnt_n    = CW'(T_CHOCOLATE - 1);
          end else begin
            estado_n = LISTO;
            cnt_n    = '0;
          end
        end
      end
      CHOCOLATE: begin
        if (cnt == '0) begin
          estado_n = LISTO;
          cnt_n    = '0;
        end
      end
      // A still-high iniciarProceso must not start a second brew.
      LISTO, ABORTO: begin
        cnt_n    = '0;
        estado_n = iniciarProceso ? REARME : IDLE;
      end
      REARME: begin
        cnt_n = '0;
        if (!iniciarProceso) estado_n = IDLE;
      end
      default: begin
        estado_n = IDLE;
        cnt_n    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_control_preparacion.sv
// Scoreboard bench for control_preparacion: directed orders push per-cycle expected stage codes,
// and a negedge monitor pops one entry per cycle and compares all outputs.
module tb_control_preparacion;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       iniciarProceso = 1'b0;
  logic [1:0] tipoCafe = 2'd0;
  logic       cancelar = 1'b0;
  logic       calentador, valvulaCafe, valvulaLeche, valvulaChocolate;
  logic       ocupado, listo, abortado;
  logic [2:0] etapa;

  control_preparacion dut (
    .clk(clk), .reset(reset), .iniciarProceso(iniciarProceso), .tipoCafe(tipoCafe),
    .cancelar(cancelar), .calentador(calentador), .valvulaCafe(valvulaCafe),
    .valvulaLeche(valvulaLeche), .valvulaChocolate(valvulaChocolate), .ocupado(ocupado),
    .listo(listo), .abortado(abortado), .etapa(etapa)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] v;
    int         scn;
    int         idx;
  } exp_t;

  exp_t q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   scn = 0;
  int   idx = 0;

  // Output vector expected for a given stage code, straight from the output decode table.
  function automatic logic [9:0] exp_vec(input logic [2:0] e);
    return {e, e == 3'd1, e == 3'd2, e == 3'd3, e == 3'd4, e != 3'd0, e == 3'd5, e == 3'd7};
  endfunction

  task automatic push(input logic [2:0] e, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t x;
      x.v   = exp_vec(e);
      x.scn = scn;
      x.idx = idx;
      idx++;
      q.push_back(x);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int s);
    scn = s;
    idx = 0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() > 0 && k < 200) begin
      tick();
      k++;
    end
    if (q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain scn%0d: %0d entries left, required 0", scn, q.size());
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      logic [9:0] act;
      x   = q.pop_front();
      act = {etapa, calentador, valvulaCafe, valvulaLeche, valvulaChocolate, ocupado, listo, abortado};
      tests_run++;
      if (act !== x.v) begin
        tests_failed++;
        $display("FAIL scn%0d cycle%0d: outputs %b, required %b", x.scn, x.idx, act, x.v);
      end
    end
  end

  initial begin
    // Reset held two cycles: everything low.
    repeat (2) @(posedge clk);
    #1;
    start(0);
    push(3'd0, 2);
    reset = 1'b0;
    drain();

    // Type 0, one-cycle start: heater 4, coffee 3, listo at cycle 8.
    start(1);
    push(3'd0, 1); push(3'd1, 4); push(3'd2, 3); push(3'd5, 1); push(3'd0, 2);
    tipoCafe = 2'd0; iniciarProceso = 1'b1;
    tick();
    iniciarProceso = 1'b0;
    drain();

    // Type 3 with start held: 4/3/2/2, listo at cycle 12, then REARME until release.
    start(2);
    push(3'd0, 1); push(3'd1, 4); push(3'd2, 3); push(3'd3, 2); push(3'd4, 2);
    push(3'd5, 1); push(3'd6, 3); push(3'd0, 2);
    tipoCafe = 2'd3; iniciarProceso = 1'b1;
    repeat (15) tick();
    iniciarProceso = 1'b0;
    drain();

    // Type 1, cancel in the 2nd heater cycle: abort pulse, no coffee.
    start(3);
    push(3'd0, 1); push(3'd1, 2); push(3'd7, 1); push(3'd0, 2);
    tipoCafe = 2'd1; iniciarProceso = 1'b1;
    tick();
    iniciarProceso = 1'b0;
    tick();
    cancelar = 1'b1;
    tick();
    cancelar = 1'b0;
    drain();

    // Type 2, cancel during CAFE is ignored: listo at cycle 10.
    start(4);
    push(3'd0, 1); push(3'd1, 4); push(3'd2, 3); push(3'd3, 2); push(3'd5, 1); push(3'd0, 2);
    tipoCafe = 2'd2; iniciarProceso = 1'b1;
    tick();
    iniciarProceso = 1'b0;
    repeat (4) tick();
    cancelar = 1'b1;
    repeat (3) tick();
    cancelar = 1'b0;
    drain();

    // Type 3 latched, input changed to 0 mid-brew (still reaches LECHE), reset during LECHE.
    start(5);
    push(3'd0, 1); push(3'd1, 4); push(3'd2, 3); push(3'd3, 1); push(3'd0, 3);
    tipoCafe = 2'd3; iniciarProceso = 1'b1;
    tick();
    iniciarProceso = 1'b0; tipoCafe = 2'd0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drain();

    // Start and cancel together in IDLE: cancel ignored, type 1 completes.
    start(6);
    push(3'd0, 1); push(3'd1, 4); push(3'd2, 3); push(3'd3, 2); push(3'd5, 1); push(3'd0, 2);
    tipoCafe = 2'd1; iniciarProceso = 1'b1; cancelar = 1'b1;
    tick();
    iniciarProceso = 1'b0; cancelar = 1'b0;
    drain();

    // Cancel with start still held: ABORTO then REARME until release.
    start(7);
    push(3'd0, 1); push(3'd1, 1); push(3'd7, 1); push(3'd6, 2); push(3'd0, 2);
    tipoCafe = 2'd2; iniciarProceso = 1'b1;
    tick();
    cancelar = 1'b1;
    tick();
    cancelar = 1'b0;
    repeat (2) tick();
    iniciarProceso = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
